// File: rtl/pulse_meas_pkg.sv
// Shared definitions for the pulse measurement port: FSM states, the default
// LED hold time and the saturating counter increment.
package pulse_meas_pkg;

    // Capture FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        PULSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Cycles the indicator LED stays low after each captured pulse.
    localparam int unsigned LED_HOLD_DEFAULT = 500;

    // Increment val, saturating at the all-ones value of a width-bit counter.
    // Callers widen their counter to 64 bits and cast the result back.
    function automatic logic [63:0] sat_inc(input logic [63:0] val,
                                            input int unsigned width);
        logic [63:0] max_val;
        if (width >= 64) begin
            max_val = '1;
        end else begin
            max_val = (64'd1 << width) - 64'd1;
        end
        if (val >= max_val) begin
            return max_val;
        end
        return val + 64'd1;
    endfunction

endpackage

// File: rtl/pulse_meas_port_if.sv
// Control and result bundle of one pulse measurement port. The master side
// (host logic or bench) programs the run and reads back the measurements.
interface pulse_meas_port_if #(
    parameter int _RAM_WIDTH = 32
);
    // Control towards the port
    logic                  io_armEn;
    logic                  io_clrCnt;
    logic                  io_defaultLevel;
    logic                  io_pulseIn;
    logic [15:0]           io_expectCnt;
    logic [_RAM_WIDTH-1:0] io_timeout;

    // Results from the port
    logic [_RAM_WIDTH-1:0] io_measDelay;
    logic [_RAM_WIDTH-1:0] io_measWidth;
    logic                  io_measValid;
    logic                  io_busy;
    logic                  io_done;
    logic                  io_timeoutErr;
    logic                  ind_led;
    logic [15:0]           CapCounter;

    modport master (
        output io_armEn, io_clrCnt, io_defaultLevel, io_pulseIn,
               io_expectCnt, io_timeout,
        input  io_measDelay, io_measWidth, io_measValid, io_busy,
               io_done, io_timeoutErr, ind_led, CapCounter
    );

    modport slave (
        input  io_armEn, io_clrCnt, io_defaultLevel, io_pulseIn,
               io_expectCnt, io_timeout,
        output io_measDelay, io_measWidth, io_measValid, io_busy,
               io_done, io_timeoutErr, ind_led, CapCounter
    );
endinterface

// File: rtl/sig_sync.sv
// Multi-stage synchronizer for an asynchronous input, followed by polarity
// selection and a registered-history edge detect on the resulting level.
module sig_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    input  logic invert_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    // Fewer than two stages would not resolve metastability.
    localparam int N = (STAGES < 2) ? 2 : STAGES;

    logic [N-1:0] sync_q;
    logic [N-1:0] sync_d;
    logic         prev_q;
    logic         prev_d;

    // Shift the raw input through the chain; remember last cycle's level.
    always_comb begin
        sync_d = {sync_q[N-2:0], async_i};
        prev_d = level_o;
    end

    // Synchronizer chain and edge-detect history register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level_o = sync_q[N-1] ^ invert_i;
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/pulse_meas_port.sv
// Pulse measurement port: once armed, times the delay before each pulse on
// one monitored input and the pulse's active width, counts pulses up to the
// expected total, flags timeouts and drives an activity LED.
module pulse_meas_port
    import pulse_meas_pkg::*;
#(
    parameter int          _RAM_WIDTH  = 32,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned LED_HOLD    = LED_HOLD_DEFAULT
) (
    input  logic             io_clk,
    input  logic             io_rst_n,
    pulse_meas_port_if.slave bus
);
    localparam int unsigned RW = unsigned'(_RAM_WIDTH);

    // Synchronized, polarity-corrected input
    logic act_level;
    logic act_rise;
    logic act_fall;

    // Arm edge detect
    logic arm_prev_q, arm_prev_d;
    logic arm_edge;

    // FSM and measurement counters
    state_e          state_q, state_d;
    logic [RW-1:0]   delay_cnt_q, delay_cnt_d;
    logic [RW-1:0]   width_cnt_q, width_cnt_d;
    logic [15:0]     run_cnt_q, run_cnt_d;
    logic [15:0]     run_next;
    logic [15:0]     run_target;
    logic            timeout_en;
    logic            cap_inc;

    // Registered outputs
    logic [RW-1:0]   meas_delay_q, meas_delay_d;
    logic [RW-1:0]   meas_width_q, meas_width_d;
    logic            meas_valid_q, meas_valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            timeout_err_q, timeout_err_d;
    logic [15:0]     cap_cnt_q, cap_cnt_d;
    logic [31:0]     led_cnt_q, led_cnt_d;
    logic            ind_led_q, ind_led_d;

    sig_sync #(
        .STAGES (SYNC_STAGES)
    ) u_pulse_sync (
        .clk      (io_clk),
        .rst_n    (io_rst_n),
        .async_i  (bus.io_pulseIn),
        .invert_i (bus.io_defaultLevel),
        .level_o  (act_level),
        .rise_o   (act_rise),
        .fall_o   (act_fall)
    );

    assign arm_edge   = bus.io_armEn & ~arm_prev_q;
    assign run_target = (bus.io_expectCnt == 16'd0) ? 16'd1 : bus.io_expectCnt;
    assign timeout_en = (bus.io_timeout != '0);

    // Capture FSM: next state, measurement counters and published results.
    always_comb begin
        state_d       = state_q;
        delay_cnt_d   = delay_cnt_q;
        width_cnt_d   = width_cnt_q;
        run_cnt_d     = run_cnt_q;
        run_next      = 16'(sat_inc(64'(run_cnt_q), 16));
        meas_delay_d  = meas_delay_q;
        meas_width_d  = meas_width_q;
        meas_valid_d  = 1'b0;
        timeout_err_d = timeout_err_q;
        cap_inc       = 1'b0;
        arm_prev_d    = bus.io_armEn;

        if (arm_edge) begin
            // An arm edge always restarts the run; a pulse in flight is dropped.
            state_d       = WAIT;
            delay_cnt_d   = '0;
            width_cnt_d   = '0;
            run_cnt_d     = '0;
            timeout_err_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    state_d = state_q;
                end
                WAIT: begin
                    if (timeout_en && (delay_cnt_q == bus.io_timeout)) begin
                        state_d       = DONE;
                        timeout_err_d = 1'b1;
                    end else if (act_rise) begin
                        // Only a leading edge starts a pulse, so an input
                        // already active when armed is never measured.
                        state_d     = PULSE;
                        width_cnt_d = RW'(1);
                    end else if (!act_level) begin
                        delay_cnt_d = RW'(sat_inc(64'(delay_cnt_q), RW));
                    end
                end
                PULSE: begin
                    if (timeout_en && (width_cnt_q == bus.io_timeout)) begin
                        state_d       = DONE;
                        timeout_err_d = 1'b1;
                    end else if (act_fall) begin
                        meas_delay_d = delay_cnt_q;
                        meas_width_d = width_cnt_q;
                        meas_valid_d = 1'b1;
                        cap_inc      = 1'b1;
                        run_cnt_d    = run_next;
                        // The trailing-edge cycle is itself inactive, so the
                        // gap to the next pulse already counts one cycle.
                        delay_cnt_d  = RW'(1);
                        state_d      = (run_next >= run_target) ? DONE : WAIT;
                    end else if (act_level) begin
                        width_cnt_d = RW'(sat_inc(64'(width_cnt_q), RW));
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Status flags, capture counter and LED hold countdown.
    always_comb begin
        busy_d = (state_d == WAIT) || (state_d == PULSE);
        // On a completed run done trails the final strobe by one cycle; after
        // a timeout it follows the timeout condition directly.
        done_d = (state_d == DONE) && !meas_valid_d;

        cap_cnt_d = cap_cnt_q;
        if (bus.io_clrCnt) begin
            cap_cnt_d = 16'd0;
        end else if (cap_inc) begin
            cap_cnt_d = 16'(sat_inc(64'(cap_cnt_q), 16));
        end

        if (meas_valid_q) begin
            led_cnt_d = 32'(LED_HOLD);
        end else if (led_cnt_q != 32'd0) begin
            led_cnt_d = led_cnt_q - 32'd1;
        end else begin
            led_cnt_d = 32'd0;
        end
        ind_led_d = (led_cnt_d == 32'd0);
    end

    // State, counter and output registers.
    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            state_q       <= IDLE;
            arm_prev_q    <= 1'b0;
            delay_cnt_q   <= '0;
            width_cnt_q   <= '0;
            run_cnt_q     <= '0;
            meas_delay_q  <= '0;
            meas_width_q  <= '0;
            meas_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            cap_cnt_q     <= '0;
            led_cnt_q     <= '0;
            ind_led_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            arm_prev_q    <= arm_prev_d;
            delay_cnt_q   <= delay_cnt_d;
            width_cnt_q   <= width_cnt_d;
            run_cnt_q     <= run_cnt_d;
            meas_delay_q  <= meas_delay_d;
            meas_width_q  <= meas_width_d;
            meas_valid_q  <= meas_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
            cap_cnt_q     <= cap_cnt_d;
            led_cnt_q     <= led_cnt_d;
            ind_led_q     <= ind_led_d;
        end
    end

    assign bus.io_measDelay  = meas_delay_q;
    assign bus.io_measWidth  = meas_width_q;
    assign bus.io_measValid  = meas_valid_q;
    assign bus.io_busy       = busy_q;
    assign bus.io_done       = done_q;
    assign bus.io_timeoutErr = timeout_err_q;
    assign bus.CapCounter    = cap_cnt_q;
    assign bus.ind_led       = ind_led_q;

endmodule

// File: tb/tb_pulse_meas_port.sv
// Directed bench for pulse_meas_port. Cycle 0 of each step is the cycle in
// which io_armEn is driven high; inputs are driven and outputs sampled 1 ns
// after each rising edge.
module tb_pulse_meas_port;
    localparam int RW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   strobes;

    always #5 clk = ~clk;

    pulse_meas_port_if #(._RAM_WIDTH(RW)) bus ();

    pulse_meas_port #(
        ._RAM_WIDTH  (RW),
        .SYNC_STAGES (2),
        .LED_HOLD    (500)
    ) dut (
        .io_clk   (clk),
        .io_rst_n (rst_n),
        .bus      (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        bus.io_armEn        = 1'b0;
        bus.io_clrCnt       = 1'b0;
        bus.io_defaultLevel = 1'b0;
        bus.io_pulseIn      = 1'b0;
        bus.io_expectCnt    = 16'd1;
        bus.io_timeout      = '0;

        // Reset values
        tick();
        tick();
        check("rst_delay", 32'(bus.io_measDelay), 32'd0);
        check("rst_width", 32'(bus.io_measWidth), 32'd0);
        check("rst_valid", 32'(bus.io_measValid), 32'd0);
        check("rst_busy", 32'(bus.io_busy), 32'd0);
        check("rst_done", 32'(bus.io_done), 32'd0);
        check("rst_terr", 32'(bus.io_timeoutErr), 32'd0);
        check("rst_led", 32'(bus.ind_led), 32'd1);
        check("rst_cap", 32'(bus.CapCounter), 32'd0);
        rst_n = 1'b1;
        repeat (5) tick();

        // Step 1: level 0, one pulse D=10 W=25
        strobes = 0;
        for (int c = 0; c <= 540; c++) begin
            bus.io_armEn   = (c == 0);
            bus.io_pulseIn = (c >= 10 && c <= 34);
            if (bus.io_measValid) strobes++;
            if (c == 20) check("t1_busy", 32'(bus.io_busy), 32'd1);
            if (c == 37) check("t1_valid_early", 32'(bus.io_measValid), 32'd0);
            if (c == 38) begin
                check("t1_valid", 32'(bus.io_measValid), 32'd1);
                check("t1_delay", 32'(bus.io_measDelay), 32'd11);
                check("t1_width", 32'(bus.io_measWidth), 32'd25);
                check("t1_cap", 32'(bus.CapCounter), 32'd1);
                check("t1_done_early", 32'(bus.io_done), 32'd0);
                check("t1_led_before", 32'(bus.ind_led), 32'd1);
            end
            if (c == 39) begin
                check("t1_done", 32'(bus.io_done), 32'd1);
                check("t1_busy_end", 32'(bus.io_busy), 32'd0);
                check("t1_led_low", 32'(bus.ind_led), 32'd0);
            end
            if (c == 538) check("t1_led_last_low", 32'(bus.ind_led), 32'd0);
            if (c == 539) check("t1_led_back", 32'(bus.ind_led), 32'd1);
            tick();
        end
        check("t1_strobes", 32'(strobes), 32'd1);

        // Step 2: idle-high input, three low pulses W=4 with gaps of 7
        bus.io_defaultLevel = 1'b1;
        bus.io_pulseIn      = 1'b1;
        bus.io_expectCnt    = 16'd3;
        repeat (10) tick();
        strobes = 0;
        for (int c = 0; c <= 40; c++) begin
            bus.io_armEn   = (c == 0);
            bus.io_clrCnt  = (c == 0);
            bus.io_pulseIn = ((c >= 5 && c <= 8) || (c >= 16 && c <= 19) ||
                              (c >= 27 && c <= 30)) ? 1'b0 : 1'b1;
            if (bus.io_measValid) strobes++;
            if (c == 1) check("t2_cap_clr", 32'(bus.CapCounter), 32'd0);
            if (c == 12) begin
                check("t2_valid1", 32'(bus.io_measValid), 32'd1);
                check("t2_delay1", 32'(bus.io_measDelay), 32'd6);
                check("t2_width1", 32'(bus.io_measWidth), 32'd4);
            end
            if (c == 23) begin
                check("t2_valid2", 32'(bus.io_measValid), 32'd1);
                check("t2_delay2", 32'(bus.io_measDelay), 32'd7);
                check("t2_width2", 32'(bus.io_measWidth), 32'd4);
                check("t2_done_mid", 32'(bus.io_done), 32'd0);
            end
            if (c == 34) begin
                check("t2_valid3", 32'(bus.io_measValid), 32'd1);
                check("t2_delay3", 32'(bus.io_measDelay), 32'd7);
                check("t2_width3", 32'(bus.io_measWidth), 32'd4);
                check("t2_cap", 32'(bus.CapCounter), 32'd3);
                check("t2_done_early", 32'(bus.io_done), 32'd0);
            end
            if (c == 35) check("t2_done", 32'(bus.io_done), 32'd1);
            tick();
        end
        check("t2_strobes", 32'(strobes), 32'd3);

        // Step 3: timeout 50 in WAIT with no input
        bus.io_defaultLevel = 1'b0;
        bus.io_pulseIn      = 1'b0;
        bus.io_expectCnt    = 16'd1;
        bus.io_timeout      = 8'd50;
        repeat (10) tick();
        strobes = 0;
        for (int c = 0; c <= 60; c++) begin
            bus.io_armEn = (c == 0);
            if (bus.io_measValid) strobes++;
            if (c == 51) begin
                check("t3_done_early", 32'(bus.io_done), 32'd0);
                check("t3_terr_early", 32'(bus.io_timeoutErr), 32'd0);
                check("t3_busy", 32'(bus.io_busy), 32'd1);
            end
            if (c == 52) begin
                check("t3_done", 32'(bus.io_done), 32'd1);
                check("t3_terr", 32'(bus.io_timeoutErr), 32'd1);
                check("t3_busy_end", 32'(bus.io_busy), 32'd0);
            end
            tick();
        end
        check("t3_strobes", 32'(strobes), 32'd0);

        // Step 4: re-arm, input active for 100 cycles, timeout in PULSE
        strobes = 0;
        for (int c = 0; c <= 110; c++) begin
            bus.io_armEn   = (c == 0);
            bus.io_pulseIn = (c >= 2 && c <= 101);
            if (bus.io_measValid) strobes++;
            if (c == 1) check("t4_terr_cleared", 32'(bus.io_timeoutErr), 32'd0);
            if (c == 54) begin
                check("t4_terr_early", 32'(bus.io_timeoutErr), 32'd0);
                check("t4_busy", 32'(bus.io_busy), 32'd1);
            end
            if (c == 55) begin
                check("t4_terr", 32'(bus.io_timeoutErr), 32'd1);
                check("t4_done", 32'(bus.io_done), 32'd1);
            end
            tick();
        end
        check("t4_strobes", 32'(strobes), 32'd0);
        bus.io_timeout = '0;

        // Step 5: expect 2; one pulse, then a pulse aborted by a re-arm
        strobes = 0;
        for (int c = 0; c <= 70; c++) begin
            bus.io_armEn   = (c == 0) || (c == 46);
            bus.io_expectCnt = 16'd2;
            bus.io_pulseIn = (c >= 3 && c <= 7) || (c >= 15 && c <= 44) ||
                             (c >= 56 && c <= 60);
            if (c >= 12 && c <= 63 && bus.io_measValid) strobes++;
            if (c == 11) begin
                check("t5_valid_a", 32'(bus.io_measValid), 32'd1);
                check("t5_delay_a", 32'(bus.io_measDelay), 32'd4);
                check("t5_width_a", 32'(bus.io_measWidth), 32'd5);
            end
            if (c == 64) begin
                check("t5_valid_c", 32'(bus.io_measValid), 32'd1);
                check("t5_delay_c", 32'(bus.io_measDelay), 32'd11);
                check("t5_width_c", 32'(bus.io_measWidth), 32'd5);
                check("t5_cap", 32'(bus.CapCounter), 32'd5);
            end
            if (c == 65) begin
                check("t5_not_done", 32'(bus.io_done), 32'd0);
                check("t5_still_busy", 32'(bus.io_busy), 32'd1);
            end
            tick();
        end
        check("t5_aborted_strobes", 32'(strobes), 32'd0);

        // Step 6: expect 0 (one pulse), clear coincident with the strobe
        for (int c = 0; c <= 12; c++) begin
            bus.io_armEn     = (c == 0);
            bus.io_expectCnt = 16'd0;
            bus.io_pulseIn   = (c >= 2 && c <= 4);
            bus.io_clrCnt    = (c == 7) || (c == 8);
            if (c == 6) check("t6_cap_before", 32'(bus.CapCounter), 32'd5);
            if (c == 8) begin
                check("t6_valid", 32'(bus.io_measValid), 32'd1);
                check("t6_delay", 32'(bus.io_measDelay), 32'd3);
                check("t6_width", 32'(bus.io_measWidth), 32'd3);
                check("t6_cap_clr", 32'(bus.CapCounter), 32'd0);
            end
            if (c == 9) begin
                check("t6_cap_after", 32'(bus.CapCounter), 32'd0);
                check("t6_done", 32'(bus.io_done), 32'd1);
            end
            tick();
        end
        bus.io_clrCnt = 1'b0;

        // Step 7: delay counter saturates at all-ones
        bus.io_expectCnt = 16'd1;
        for (int c = 0; c <= 310; c++) begin
            bus.io_armEn   = (c == 0);
            bus.io_pulseIn = (c >= 300 && c <= 302);
            if (c == 306) begin
                check("t7_valid", 32'(bus.io_measValid), 32'd1);
                check("t7_delay_sat", 32'(bus.io_measDelay), 32'd255);
                check("t7_width", 32'(bus.io_measWidth), 32'd3);
            end
            tick();
        end

        // Step 8: reset asserted mid-PULSE
        for (int c = 0; c <= 20; c++) begin
            bus.io_armEn   = (c == 0);
            bus.io_pulseIn = (c >= 2 && c <= 40);
            if (c < 20) tick();
        end
        check("t8_busy_pre", 32'(bus.io_busy), 32'd1);
        check("t8_cap_pre", 32'(bus.CapCounter), 32'd1);
        check("t8_led_pre", 32'(bus.ind_led), 32'd0);
        rst_n = 1'b0;
        #1;
        check("t8_delay", 32'(bus.io_measDelay), 32'd0);
        check("t8_width", 32'(bus.io_measWidth), 32'd0);
        check("t8_valid", 32'(bus.io_measValid), 32'd0);
        check("t8_busy", 32'(bus.io_busy), 32'd0);
        check("t8_done", 32'(bus.io_done), 32'd0);
        check("t8_terr", 32'(bus.io_timeoutErr), 32'd0);
        check("t8_led", 32'(bus.ind_led), 32'd1);
        check("t8_cap", 32'(bus.CapCounter), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
